// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Holds the minimum divisor, the divisor clamp and the ceil-half expression.
package clk_div_pkg;

    localparam int DIV_MIN = 2;

    // Requested divisors below DIV_MIN would stall or degenerate the counter.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
    endfunction

    // Number of high cycles in one period: ceil(D/2).
    function automatic logic [31:0] ceil_half(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Divisor handshake and shadow register for clk_div_prog.
// Ports: i_clk, i_rst, i_div_in/i_div_valid (request), i_apply (strobe from top),
//        o_div_ready, o_shadow (clamped divisor), o_pend_valid.
module clk_div_shadow
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_div_in,
    input  logic             i_div_valid,
    input  logic             i_apply,
    output logic             o_div_ready,
    output logic [CNT_W-1:0] o_shadow,
    output logic             o_pend_valid
);

    logic             r_ready;
    logic             r_pend;
    logic [CNT_W-1:0] r_shadow;
    logic             w_xfer;
    logic [CNT_W-1:0] w_clamped;

    assign w_xfer    = i_div_valid && r_ready;
    assign w_clamped = CNT_W'(clamp_div(32'(i_div_in)));

    // Only one divisor can be outstanding; ready returns once it is applied.
    // Transfer and apply never coincide since apply needs r_pend (ready low).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ready  <= 1'b1;
            r_pend   <= 1'b0;
            r_shadow <= CNT_W'(DIV_MIN);
        end else if (w_xfer) begin
            r_shadow <= w_clamped;
            r_pend   <= 1'b1;
            r_ready  <= 1'b0;
        end else if (i_apply) begin
            r_pend   <= 1'b0;
            r_ready  <= 1'b1;
        end
    end

    assign o_div_ready  = r_ready;
    assign o_shadow     = r_shadow;
    assign o_pend_valid = r_pend;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with tick enable.
// Ports: clk, reset (async, active-high), en, div_in/div_valid/div_ready,
//        clk_out (registered, ~50% duty), tick (first high cycle), cur_div.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] cur_div
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic             r_clk_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_wrap;
    logic             w_high;
    logic             w_apply;
    logic [CNT_W-1:0] w_shadow;
    logic             w_pend;

    clk_div_shadow #(
        .CNT_W(CNT_W)
    ) u_shadow (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_div_in    (div_in),
        .i_div_valid (div_valid),
        .i_apply     (w_apply),
        .o_div_ready (div_ready),
        .o_shadow    (w_shadow),
        .o_pend_valid(w_pend)
    );

    assign w_cnt_next = (r_cnt == r_div - CNT_W'(1)) ? '0 : r_cnt + CNT_W'(1);
    assign w_wrap     = (w_cnt_next == '0);
    assign w_high     = 32'(w_cnt_next) < ceil_half(32'(r_div));

    // w_pend is the pre-edge value, so a divisor captured on a wrap edge
    // waits a full period. The wrap itself is computed with the old D,
    // so the new D only governs the period that starts here: no runt pulse.
    assign w_apply = en && w_wrap && w_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_div     <= CNT_W'(RESET_DIV);
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (en) begin
            r_cnt     <= w_cnt_next;
            r_clk_out <= w_high;
            r_tick    <= w_wrap;
            if (w_apply) begin
                r_div <= w_shadow;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign cur_div = r_div;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed testbench for clk_div_prog (CNT_W=8, RESET_DIV=2).
// Drives inputs on negedge, samples outputs on negedge after each posedge.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] div_in = 8'd0;
    logic       div_valid = 1'b0;
    logic       div_ready;
    logic       clk_out;
    logic       tick;
    logic [7:0] cur_div;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_prog #(
        .CNT_W(8),
        .RESET_DIV(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .div_in   (div_in),
        .div_valid(div_valid),
        .div_ready(div_ready),
        .clk_out  (clk_out),
        .tick     (tick),
        .cur_div  (cur_div)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b0;
        step();
        step();
        n_checks++; if (clk_out !== 1'b0) begin n_errors++; $display("FAIL rst_clk_out: got %0b exp 0", clk_out); end
        n_checks++; if (tick !== 1'b0) begin n_errors++; $display("FAIL rst_tick: got %0b exp 0", tick); end
        n_checks++; if (div_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %0b exp 1", div_ready); end
        n_checks++; if (cur_div !== 8'd2) begin n_errors++; $display("FAIL rst_cur_div: got %0d exp 2", cur_div); end
        reset = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_div2();
        for (int k = 1; k <= 6; k++) begin
            logic e;
            step();
            e = (k % 2 == 0);
            n_checks++; if (clk_out !== e) begin n_errors++; $display("FAIL div2_clk edge %0d: got %0b exp %0b", k, clk_out, e); end
            n_checks++; if (tick !== e) begin n_errors++; $display("FAIL div2_tick edge %0d: got %0b exp %0b", k, tick, e); end
        end
    endtask

    task automatic test_div5();
        div_in = 8'd5;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        n_checks++; if (div_ready !== 1'b0) begin n_errors++; $display("FAIL div5_ready_low: got %0b exp 0", div_ready); end
        n_checks++; if (clk_out !== 1'b0) begin n_errors++; $display("FAIL div5_old_period: got %0b exp 0", clk_out); end
        n_checks++; if (cur_div !== 8'd2) begin n_errors++; $display("FAIL div5_cur_before: got %0d exp 2", cur_div); end
        step();
        n_checks++; if (cur_div !== 8'd5) begin n_errors++; $display("FAIL div5_cur_apply: got %0d exp 5", cur_div); end
        n_checks++; if (div_ready !== 1'b1) begin n_errors++; $display("FAIL div5_ready_back: got %0b exp 1", div_ready); end
        n_checks++; if (tick !== 1'b1) begin n_errors++; $display("FAIL div5_tick_apply: got %0b exp 1", tick); end
        n_checks++; if (clk_out !== 1'b1) begin n_errors++; $display("FAIL div5_clk_apply: got %0b exp 1", clk_out); end
        for (int j = 1; j <= 10; j++) begin
            logic ec;
            logic et;
            step();
            ec = ((j % 5) < 3);
            et = ((j % 5) == 0);
            n_checks++; if (clk_out !== ec) begin n_errors++; $display("FAIL div5_clk j=%0d: got %0b exp %0b", j, clk_out, ec); end
            n_checks++; if (tick !== et) begin n_errors++; $display("FAIL div5_tick j=%0d: got %0b exp %0b", j, tick, et); end
        end
    endtask

    task automatic test_clamp0();
        div_in = 8'd0;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        n_checks++; if (div_ready !== 1'b0) begin n_errors++; $display("FAIL clamp_ready_low: got %0b exp 0", div_ready); end
        repeat (3) step();
        n_checks++; if (cur_div !== 8'd5) begin n_errors++; $display("FAIL clamp_early: got %0d exp 5", cur_div); end
        step();
        n_checks++; if (cur_div !== 8'd2) begin n_errors++; $display("FAIL clamp_cur_div: got %0d exp 2", cur_div); end
        n_checks++; if (tick !== 1'b1) begin n_errors++; $display("FAIL clamp_tick: got %0b exp 1", tick); end
        for (int j = 1; j <= 4; j++) begin
            logic e;
            step();
            e = (j % 2 == 0);
            n_checks++; if (clk_out !== e) begin n_errors++; $display("FAIL clamp_clk j=%0d: got %0b exp %0b", j, clk_out, e); end
        end
    endtask

    task automatic test_wrap_edge();
        step();
        div_in = 8'd3;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        n_checks++; if (tick !== 1'b1) begin n_errors++; $display("FAIL wrap_tick: got %0b exp 1", tick); end
        n_checks++; if (cur_div !== 8'd2) begin n_errors++; $display("FAIL wrap_not_applied: got %0d exp 2", cur_div); end
        step();
        n_checks++; if (clk_out !== 1'b0) begin n_errors++; $display("FAIL wrap_old_low: got %0b exp 0", clk_out); end
        n_checks++; if (cur_div !== 8'd2) begin n_errors++; $display("FAIL wrap_still_old: got %0d exp 2", cur_div); end
        step();
        n_checks++; if (cur_div !== 8'd3) begin n_errors++; $display("FAIL wrap_apply: got %0d exp 3", cur_div); end
        n_checks++; if (tick !== 1'b1) begin n_errors++; $display("FAIL wrap_apply_tick: got %0b exp 1", tick); end
        step();
        n_checks++; if (clk_out !== 1'b1) begin n_errors++; $display("FAIL div3_high2: got %0b exp 1", clk_out); end
        step();
        n_checks++; if (clk_out !== 1'b0) begin n_errors++; $display("FAIL div3_low: got %0b exp 0", clk_out); end
        step();
        n_checks++; if (tick !== 1'b1) begin n_errors++; $display("FAIL div3_tick: got %0b exp 1", tick); end
    endtask

    task automatic test_max();
        int highs;
        int ticks;
        logic c127;
        logic c128;
        highs = 0;
        ticks = 0;
        c127 = 1'b0;
        c128 = 1'b1;
        div_in = 8'd255;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        step();
        n_checks++; if (cur_div !== 8'd3) begin n_errors++; $display("FAIL max_early: got %0d exp 3", cur_div); end
        step();
        n_checks++; if (cur_div !== 8'd255) begin n_errors++; $display("FAIL max_apply: got %0d exp 255", cur_div); end
        for (int j = 1; j <= 255; j++) begin
            step();
            if (clk_out === 1'b1) highs++;
            if (tick === 1'b1) ticks++;
            if (j == 127) c127 = clk_out;
            if (j == 128) c128 = clk_out;
        end
        n_checks++; if (highs !== 128) begin n_errors++; $display("FAIL max_high_cycles: got %0d exp 128", highs); end
        n_checks++; if (ticks !== 1) begin n_errors++; $display("FAIL max_ticks: got %0d exp 1", ticks); end
        n_checks++; if (c127 !== 1'b1) begin n_errors++; $display("FAIL max_last_high: got %0b exp 1", c127); end
        n_checks++; if (c128 !== 1'b0) begin n_errors++; $display("FAIL max_first_low: got %0b exp 0", c128); end
        n_checks++; if (tick !== 1'b1) begin n_errors++; $display("FAIL max_period_end: got %0b exp 1", tick); end
    endtask

    task automatic test_enable();
        int bad;
        bad = 0;
        repeat (10) step();
        en = 1'b0;
        div_in = 8'd7;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        n_checks++; if (div_ready !== 1'b0) begin n_errors++; $display("FAIL en_xfer: got %0b exp 0", div_ready); end
        n_checks++; if (clk_out !== 1'b1) begin n_errors++; $display("FAIL en_hold_high: got %0b exp 1", clk_out); end
        repeat (6) begin
            step();
            if (clk_out !== 1'b1 || tick !== 1'b0 || cur_div !== 8'd255) bad++;
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL en_frozen: got %0d bad cycles exp 0", bad); end
        en = 1'b1;
        for (int j = 1; j <= 245; j++) begin
            step();
            if (j == 117) begin
                n_checks++; if (clk_out !== 1'b1) begin n_errors++; $display("FAIL en_resume_high: got %0b exp 1", clk_out); end
            end
            if (j == 118) begin
                n_checks++; if (clk_out !== 1'b0) begin n_errors++; $display("FAIL en_resume_low: got %0b exp 0", clk_out); end
            end
            if (j == 244) begin
                n_checks++; if (cur_div !== 8'd255) begin n_errors++; $display("FAIL en_pre_apply: got %0d exp 255", cur_div); end
            end
        end
        n_checks++; if (cur_div !== 8'd7) begin n_errors++; $display("FAIL en_apply: got %0d exp 7", cur_div); end
        n_checks++; if (tick !== 1'b1) begin n_errors++; $display("FAIL en_apply_tick: got %0b exp 1", tick); end
        div_in = 8'd4;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        repeat (5) step();
        en = 1'b0;
        repeat (3) step();
        n_checks++; if (cur_div !== 8'd7) begin n_errors++; $display("FAIL en0_no_apply: got %0d exp 7", cur_div); end
        n_checks++; if (tick !== 1'b0) begin n_errors++; $display("FAIL en0_tick: got %0b exp 0", tick); end
        n_checks++; if (clk_out !== 1'b0) begin n_errors++; $display("FAIL en0_hold_low: got %0b exp 0", clk_out); end
        en = 1'b1;
        step();
        n_checks++; if (cur_div !== 8'd4) begin n_errors++; $display("FAIL en1_apply: got %0d exp 4", cur_div); end
        n_checks++; if (tick !== 1'b1) begin n_errors++; $display("FAIL en1_tick: got %0b exp 1", tick); end
        n_checks++; if (div_ready !== 1'b1) begin n_errors++; $display("FAIL en1_ready: got %0b exp 1", div_ready); end
    endtask

    task automatic test_reset_mid();
        div_in = 8'd9;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        n_checks++; if (clk_out !== 1'b1) begin n_errors++; $display("FAIL rmid_pre_clk: got %0b exp 1", clk_out); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (clk_out !== 1'b0) begin n_errors++; $display("FAIL rmid_clk: got %0b exp 0", clk_out); end
        n_checks++; if (tick !== 1'b0) begin n_errors++; $display("FAIL rmid_tick: got %0b exp 0", tick); end
        n_checks++; if (div_ready !== 1'b1) begin n_errors++; $display("FAIL rmid_ready: got %0b exp 1", div_ready); end
        n_checks++; if (cur_div !== 8'd2) begin n_errors++; $display("FAIL rmid_cur_div: got %0d exp 2", cur_div); end
        @(negedge clk);
        reset = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            logic e;
            step();
            e = (j % 2 == 0);
            n_checks++; if (tick !== e) begin n_errors++; $display("FAIL rmid_tick j=%0d: got %0b exp %0b", j, tick, e); end
        end
        n_checks++; if (cur_div !== 8'd2) begin n_errors++; $display("FAIL rmid_discard: got %0d exp 2", cur_div); end
    endtask

    initial begin
        test_reset();
        test_div2();
        test_div5();
        test_clamp0();
        test_wrap_edge();
        test_max();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
